// File: rtl/stream_packetizer.sv
// -----------------------------------------------------------------------------
// stream_packetizer
//   Frames a valid/ready word stream into packets: up to PKT_WORDS payload
//   words followed by one checksum word (modular sum of the payload, carry
//   discarded). i_last closes a packet early. A single output register holds
//   the current output word; i_ready is combinational from that register.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   i_valid    upstream word valid
//   i_ready    block accepts the upstream word this cycle
//   i_data     upstream payload word
//   i_last     upstream word closes the packet early
//   o_valid    output word valid
//   o_ready    downstream accepts the output word
//   o_data     output word (payload or checksum)
//   o_last     output word is the packet checksum
//   pkt_count  completed-packet counter (wraps at 16 bits)
//
// States
//   PAYLOAD  | accepting payload words, forwarding them to the output register
//   CHECKSUM | packet closed; loading the checksum when the output slot frees
// -----------------------------------------------------------------------------
module stream_packetizer #(
    parameter int DATA_LENGHT = 16,
    parameter int PKT_WORDS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [DATA_LENGHT-1:0] i_data,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [DATA_LENGHT-1:0] o_data,
    output logic                   o_last,
    output logic [15:0]            pkt_count
);

    // One extra bit so PKT_WORDS itself stays representable.
    localparam int                CNT_W    = $clog2(PKT_WORDS) + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PKT_WORDS - 1);

    typedef enum logic {
        PAYLOAD  = 1'b0,
        CHECKSUM = 1'b1
    } state_t;

    state_t                 state_q;
    logic [DATA_LENGHT-1:0] sum_q;
    logic [DATA_LENGHT-1:0] sum_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [DATA_LENGHT-1:0] o_data_q;
    logic                   o_last_q;
    logic                   o_valid_q;
    logic [15:0]            pkt_count_q;

    logic slot_free;
    logic in_xfer;
    logic close_pkt;

    assign slot_free = !o_valid_q || o_ready;
    assign i_ready   = (state_q == PAYLOAD) && slot_free && !rst;
    assign in_xfer   = i_valid && i_ready;

    // Carry out of the top bit is dropped by the width of sum_d.
    assign sum_d     = sum_q + i_data;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign close_pkt = (cnt_q == LAST_IDX) || i_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAYLOAD;
            sum_q       <= '0;
            cnt_q       <= '0;
            o_data_q    <= '0;
            o_last_q    <= 1'b0;
            o_valid_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            case (state_q)
                PAYLOAD: begin
                    if (in_xfer) begin
                        o_data_q  <= i_data;
                        o_last_q  <= 1'b0;
                        o_valid_q <= 1'b1;
                        sum_q     <= sum_d;
                        cnt_q     <= cnt_d;
                        if (close_pkt) begin
                            state_q <= CHECKSUM;
                        end
                    end else if (slot_free) begin
                        o_valid_q <= 1'b0;
                    end
                end
                CHECKSUM: begin
                    if (slot_free) begin
                        o_data_q    <= sum_q;
                        o_last_q    <= 1'b1;
                        o_valid_q   <= 1'b1;
                        sum_q       <= '0;
                        cnt_q       <= '0;
                        pkt_count_q <= pkt_count_q + 16'd1;
                        state_q     <= PAYLOAD;
                    end
                end
                default: begin
                    state_q <= PAYLOAD;
                end
            endcase
        end
    end

    assign o_data    = o_data_q;
    assign o_last    = o_last_q;
    assign o_valid   = o_valid_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stream_packetizer.sv
module tb_stream_packetizer;

    localparam int DW = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic [15:0]   pkt_count;

    stream_packetizer #(.DATA_LENGHT(DW), .PKT_WORDS(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_last    (o_last),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: expected output words {last, data} in order.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] m_sum = '0;
    int            m_cnt = 0;
    logic [DW-1:0] last_ck = '0;
    logic [DW:0]   out_log [0:15];
    int            out_n = 0;
    logic          stream_on = 1'b0;
    logic          stream_rdy [0:31];
    int            stream_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Inputs change at posedge+1, so the values seen here decide the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_sum = '0;
            m_cnt = 0;
        end else begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("o_word_unexpected");
                end else begin
                    chk("o_word", 32'({o_last, o_data}), 32'(exp_q[0]));
                    if (o_ready) begin
                        if (o_last) last_ck = o_data;
                        if (out_n < 16) out_log[out_n] = {o_last, o_data};
                        out_n++;
                        void'(exp_q.pop_front());
                    end
                end
                if (!o_ready) chk("i_ready_stall", 32'(i_ready), 32'd0);
            end
            if (i_valid && i_ready) begin
                exp_q.push_back({1'b0, i_data});
                m_sum = m_sum + i_data;
                m_cnt++;
                if (m_cnt == PW || i_last) begin
                    exp_q.push_back({1'b1, m_sum});
                    m_sum = '0;
                    m_cnt = 0;
                end
            end
            if (stream_on && stream_n < 32) begin
                stream_rdy[stream_n] = i_ready;
                stream_n++;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        logic took;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        took    = 1'b0;
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = i_ready;
            @(posedge clk);
            #1;
        end
        if (!took) fail_now("send_timeout");
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 40 && (exp_q.size() != 0 || o_valid); k++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || o_valid) fail_now("drain_timeout");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_last", 32'(o_last), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_i_ready", 32'(i_ready), 32'd1);

        // Full packet
        out_n = 0;
        send_word(16'h0001, 1'b0);
        send_word(16'h0002, 1'b0);
        send_word(16'h0003, 1'b0);
        send_word(16'h0004, 1'b0);
        drain();
        chk("full_n_out", 32'(out_n), 32'd5);
        chk("full_w0", 32'(out_log[0]), 32'h00001);
        chk("full_w1", 32'(out_log[1]), 32'h00002);
        chk("full_w2", 32'(out_log[2]), 32'h00003);
        chk("full_w3", 32'(out_log[3]), 32'h00004);
        chk("full_ck", 32'(out_log[4]), 32'h1000A);
        chk("full_pkt_count", 32'(pkt_count), 32'd1);

        // Checksum wrap
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0002, 1'b0);
        send_word(16'h0000, 1'b0);
        send_word(16'h0000, 1'b0);
        drain();
        chk("wrap_ck", 32'(last_ck), 32'h0001);
        chk("wrap_pkt_count", 32'(pkt_count), 32'd2);

        // Early end, then a fresh full packet
        send_word(16'h0005, 1'b0);
        send_word(16'h0006, 1'b1);
        drain();
        chk("early_ck", 32'(last_ck), 32'h000B);
        chk("early_pkt_count", 32'(pkt_count), 32'd3);
        send_word(16'h0007, 1'b0);
        send_word(16'h0008, 1'b0);
        send_word(16'h0009, 1'b0);
        send_word(16'h000A, 1'b0);
        drain();
        chk("after_early_ck", 32'(last_ck), 32'h0022);
        chk("after_early_pkt_count", 32'(pkt_count), 32'd4);

        // Single-word packet
        send_word(16'h1234, 1'b1);
        drain();
        chk("single_ck", 32'(last_ck), 32'h1234);
        chk("single_pkt_count", 32'(pkt_count), 32'd5);

        // i_last on the final allowed word: exactly one packet
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b1);
        drain();
        chk("last_on_max_ck", 32'(last_ck), 32'h0004);
        chk("last_on_max_pkt_count", 32'(pkt_count), 32'd6);

        // Backpressure
        o_ready = 1'b0;
        send_word(16'h0011, 1'b0);
        i_valid = 1'b1;
        i_data  = 16'h0022;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_data", 32'(o_data), 32'h0011);
            chk("bp_o_last", 32'(o_last), 32'd0);
            chk("bp_i_ready", 32'(i_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        send_word(16'h0022, 1'b0);
        send_word(16'h0033, 1'b0);
        send_word(16'h0044, 1'b0);
        drain();
        chk("bp_ck", 32'(last_ck), 32'h00AA);
        chk("bp_pkt_count", 32'(pkt_count), 32'd7);

        // Reset mid-packet
        send_word(16'h0100, 1'b0);
        send_word(16'h0200, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_data", 32'(o_data), 32'd0);
        chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'h0001, 1'b0);
        drain();
        chk("post_rst_ck", 32'(last_ck), 32'h0004);
        chk("post_rst_pkt_count", 32'(pkt_count), 32'd1);

        // Streaming: 3 back-to-back packets
        stream_n  = 0;
        stream_on = 1'b1;
        for (int p = 0; p < 12; p++) begin
            send_word(16'(16'h0100 + p * 3), 1'b0);
        end
        stream_on = 1'b0;
        drain();
        chk("stream_samples", 32'(stream_n), 32'd14);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("stream_i_ready[%0d]", k), 32'(stream_rdy[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
        end
        chk("stream_pkt_count", 32'(pkt_count), 32'd4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
